// File: rtl/dmem_write_buffer_if.sv
// Bus bundle for dmem_write_buffer: MEM-stage store/load side plus the data-memory write port.
// The slave modport is the buffer's view; the master modport is the pipeline/memory environment.
interface dmem_write_buffer_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  // MEM stage side
  logic          MEM_MemWr;
  logic          MEM_MemRd;
  logic [AW-1:0] MEM_Addr;
  logic [DW-1:0] MEM_Data;
  logic          Full;
  logic          Empty;
  logic [CW-1:0] Count;
  logic          Ld_Hit;
  logic [DW-1:0] Ld_Data;
  logic          Ld_Stall;

  // Data-memory side
  logic          Bus_Req;
  logic [AW-1:0] Bus_Addr;
  logic [DW-1:0] Bus_Wdata;
  logic          Bus_Ack;

  // Bus FSM state (0 = IDLE, 1 = REQ)
  logic          dbg_state;

  modport slave (
    input  MEM_MemWr, MEM_MemRd, MEM_Addr, MEM_Data, Bus_Ack,
    output Full, Empty, Count, Ld_Hit, Ld_Data, Ld_Stall,
    output Bus_Req, Bus_Addr, Bus_Wdata, dbg_state
  );

  modport master (
    output MEM_MemWr, MEM_MemRd, MEM_Addr, MEM_Data, Bus_Ack,
    input  Full, Empty, Count, Ld_Hit, Ld_Data, Ld_Stall,
    input  Bus_Req, Bus_Addr, Bus_Wdata, dbg_state
  );
endinterface

// File: rtl/dmem_write_buffer.sv
// Posted-store write buffer between the MEM stage and data memory, with load address checking.
// Optional macro WB_FWD_EN: forward matching store data to loads instead of stalling them.
module dmem_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input logic                Clk,
  input logic                Clrn,
  dmem_write_buffer_if.slave wb
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {IDLE = 1'b0, REQ = 1'b1} state_e;

  // Handshakes: a store is taken at an edge with MEM_MemWr=1 and registered Full=0;
  // a bus write completes at an edge with Bus_Req=1 and Bus_Ack=1, and Bus_Addr/Bus_Wdata
  // are held constant from Bus_Req rising until that edge. Bus_Ack with Bus_Req=0 does nothing.
  state_e        state_q, state_d;
  logic [AW-1:0] addr_q [DEPTH];
  logic [AW-1:0] addr_d [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic [AW-1:0] bus_addr_q, bus_addr_d;
  logic [DW-1:0] bus_wdata_q, bus_wdata_d;

  logic          wr_acc;
  logic          pop;

  always_comb begin
    wr_acc      = wb.MEM_MemWr && !full_q;
    pop         = (state_q == REQ) && wb.Bus_Ack;
    addr_d      = addr_q;
    data_d      = data_q;
    valid_d     = valid_q;
    head_d      = head_q;
    tail_d      = tail_q;
    state_d     = state_q;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;

    // Enqueue and pop never touch the same slot: pop needs Count>=1, enqueue needs Count<DEPTH.
    if (wr_acc) begin
      addr_d[tail_q]  = wb.MEM_Addr;
      data_d[tail_q]  = wb.MEM_Data;
      valid_d[tail_q] = 1'b1;
      tail_d          = tail_q + 1'b1;
    end
    if (pop) begin
      valid_d[head_q] = 1'b0;
      head_d          = head_q + 1'b1;
    end

    count_d = count_q + CW'(wr_acc) - CW'(pop);
    full_d  = (count_d == CW'(DEPTH));
    empty_d = (count_d == '0);

    case (state_q)
      IDLE:    if (count_q != '0 || wr_acc) state_d = REQ;
      REQ:     if (pop && count_d == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Load the next head into the bus registers; it may be the store arriving this very edge.
    if (state_d == REQ && (state_q == IDLE || pop)) begin
      if (wr_acc && tail_q == head_d) begin
        bus_addr_d  = wb.MEM_Addr;
        bus_wdata_d = wb.MEM_Data;
      end else begin
        bus_addr_d  = addr_q[head_d];
        bus_wdata_d = data_q[head_d];
      end
    end
  end

  always_ff @(posedge Clk or negedge Clrn) begin
    if (!Clrn) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      valid_q     <= '0;
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      full_q      <= 1'b0;
      empty_q     <= 1'b1;
      state_q     <= IDLE;
      bus_addr_q  <= '0;
      bus_wdata_q <= '0;
    end else begin
      addr_q      <= addr_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      full_q      <= full_d;
      empty_q     <= empty_d;
      state_q     <= state_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
    end
  end

  // Word-address lookup, oldest to youngest so the youngest match is the one kept.
  logic          match;
  logic [DW-1:0] match_data;
  logic [PW-1:0] idx;

  always_comb begin
    match      = 1'b0;
    match_data = '0;
    idx        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + PW'(i);
      if (valid_q[idx] && addr_q[idx][AW-1:2] == wb.MEM_Addr[AW-1:2]) begin
        match      = 1'b1;
        match_data = data_q[idx];
      end
    end
  end

`ifdef WB_FWD_EN
  assign wb.Ld_Hit   = wb.MEM_MemRd && match;
  assign wb.Ld_Data  = (wb.MEM_MemRd && match) ? match_data : '0;
  assign wb.Ld_Stall = 1'b0;
`else
  assign wb.Ld_Hit   = 1'b0;
  assign wb.Ld_Data  = '0;
  assign wb.Ld_Stall = wb.MEM_MemRd && match;
`endif

  assign wb.Full      = full_q;
  assign wb.Empty     = empty_q;
  assign wb.Count     = count_q;
  assign wb.Bus_Req   = (state_q == REQ);
  assign wb.Bus_Addr  = bus_addr_q;
  assign wb.Bus_Wdata = bus_wdata_q;
  assign wb.dbg_state = state_q;
endmodule
